// File: rtl/mem_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_pkg
// Description : Shared constants and state encoding for the byte-burst memory
//               reader (mem_burst_reader and its address generator).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_burst_pkg;

    localparam int MAX_BYTES = 16;   // maximum bytes per burst / packed width in bytes
    localparam int ADDR_W    = 8;    // memory address width
    localparam int DATA_W    = 8;    // memory data width
    localparam int CNT_W     = 5;    // width of the Count input (0..MAX_BYTES)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : burst_addr_gen
// Description : Address sequencer for a burst. Holds the beat index, the
//               latched stride and the running address, which wraps modulo
//               2^ADDR_W. Flags the final beat of the burst.
// Ports       : Clk, Rst        - clock, synchronous active-high reset
//               Load            - latch BaseAddr/Stride/Count, index := 0
//               Advance         - step to the next beat (held on last beat)
//               BaseAddr,Stride - first address and per-beat increment
//               Count           - clamped beat count (>=1 when it matters)
//               Address         - current beat address
//               Index           - current beat index
//               LastBeat        - current beat is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module burst_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Load,
    input  logic              Advance,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W-1:0] Stride,
    input  logic [CNT_W-1:0]  Count,
    output logic [ADDR_W-1:0] Address,
    output logic [CNT_W-1:0]  Index,
    output logic              LastBeat
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [CNT_W-1:0]  r_index;
    logic [CNT_W-1:0]  r_last_idx;

    // The address is accumulated (addr += stride) instead of computing
    // base + index*stride; both agree modulo 2^ADDR_W and this avoids a
    // multiplier. On the last beat the address is held so it stays put
    // while the result is presented.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_addr     <= '0;
            r_stride   <= '0;
            r_index    <= '0;
            r_last_idx <= '0;
        end else if (Load) begin
            r_addr     <= BaseAddr;
            r_stride   <= Stride;
            r_index    <= '0;
            // Count==0 never enters the read phase, so the wrapped value
            // produced here is never consulted.
            r_last_idx <= Count - CNT_W'(1);
        end else if (Advance && !LastBeat) begin
            r_addr     <= r_addr + r_stride;
            r_index    <= r_index + CNT_W'(1);
        end
    end

    assign Address  = r_addr;
    assign Index    = r_index;
    assign LastBeat = (r_index == r_last_idx);

endmodule
`default_nettype wire

// File: rtl/mem_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_reader
// Description : Reads Count consecutive bytes (clamped to MAX_BYTES) from a
//               byte-wide memory bank starting at BaseAddr, one per cycle,
//               and presents them packed in Data with a Valid/Ack handshake.
//               Optional macro MEM_BURST_STRIDE_EN adds a Stride input so the
//               burst walks base + index*stride (column walks).
// Ports       : Clk, Rst          - clock, synchronous active-high reset
//               Start, BaseAddr,
//               Count, [Stride]   - burst request, sampled in IDLE only
//               Ack               - consumer accepts Data while Valid
//               Address, MemRead,
//               MemWrite          - memory bank control (MemWrite tied 0)
//               ReadData          - combinational read data from the bank
//               Data              - packed result, byte i at [8i+7:8i]
//               Valid             - Data complete and stable
//               Busy              - burst in progress or awaiting Ack
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_reader
    import mem_burst_pkg::*;
#(
    parameter int MAX_BYTES = mem_burst_pkg::MAX_BYTES,
    parameter int ADDR_W    = mem_burst_pkg::ADDR_W,
    parameter int DATA_W    = mem_burst_pkg::DATA_W
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        Start,
    input  logic [ADDR_W-1:0]           BaseAddr,
`ifdef MEM_BURST_STRIDE_EN
    input  logic [ADDR_W-1:0]           Stride,
`endif
    input  logic [CNT_W-1:0]            Count,
    input  logic                        Ack,
    output logic [ADDR_W-1:0]           Address,
    output logic                        MemRead,
    output logic                        MemWrite,
    input  logic [DATA_W-1:0]           ReadData,
    output logic [MAX_BYTES*DATA_W-1:0] Data,
    output logic                        Valid,
    output logic                        Busy
);

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_BYTES);

    state_t                        r_state;
    logic                          r_memread;
    logic                          r_valid;
    logic                          r_busy;
    logic [MAX_BYTES*DATA_W-1:0]   r_data;

    logic [CNT_W-1:0]              w_count;
    logic [ADDR_W-1:0]             w_stride;
    logic [CNT_W-1:0]              w_index;
    logic                          w_last;
    logic                          w_load;
    logic                          w_advance;

    assign w_count = (Count > c_max_cnt) ? c_max_cnt : Count;

`ifdef MEM_BURST_STRIDE_EN
    assign w_stride = Stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    assign w_load    = (r_state == IDLE) && Start;
    assign w_advance = (r_state == READ);

    burst_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_addr_gen (
        .Clk      (Clk),
        .Rst      (Rst),
        .Load     (w_load),
        .Advance  (w_advance),
        .BaseAddr (BaseAddr),
        .Stride   (w_stride),
        .Count    (w_count),
        .Address  (Address),
        .Index    (w_index),
        .LastBeat (w_last)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= IDLE;
            r_memread <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_data    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        // Clearing here is what makes bytes beyond the
                        // requested count read back as zero.
                        r_data <= '0;
                        r_busy <= 1'b1;
                        if (w_count == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state   <= READ;
                            r_memread <= 1'b1;
                        end
                    end
                end
                READ: begin
                    for (int i = 0; i < MAX_BYTES; i++) begin
                        if (w_index == CNT_W'(i)) begin
                            r_data[i*DATA_W +: DATA_W] <= ReadData;
                        end
                    end
                    if (w_last) begin
                        r_state   <= DONE;
                        r_memread <= 1'b0;
                        r_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    // A zero-length burst arrives here with Valid low; it is
                    // raised one edge later, giving a one-edge latency for
                    // N=0 just like N=1. Ack is ignored until Valid is high.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (Ack) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_memread <= 1'b0;
                    r_valid   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign MemRead  = r_memread;
    assign MemWrite = 1'b0;
    assign Data     = r_data;
    assign Valid    = r_valid;
    assign Busy     = r_busy;

endmodule
`default_nettype wire
